quantization_unit: RTL and testbench
====================================

Name: quantization_unit

Overview:
- Registered fixed-point re-quantizer: converts a wide Qm.n word to a narrower Qp.q word using rounding and saturation.
- Sits at the output of the attention datapath accumulators, e.g. Q18.16 → Q8.8, before the result feeds the next stage.
- One input word per cycle with a valid qualifier; output is registered with a 1-cycle latency.

Parameters:
- INPUT_INTEGER_WIDTH, 18, integer bits of the input, including the sign bit when SIGNED=1.
- INPUT_DECIMAL_WIDTH, 16, fraction bits of the input.
- OUTPUT_INTEGER_WIDTH, 8, integer bits of the output; must be ≤ INPUT_INTEGER_WIDTH.
- OUTPUT_DECIMAL_WIDTH, 8, fraction bits of the output; must be ≤ INPUT_DECIMAL_WIDTH.
- SIGNED, 0, 0 = unsigned formats; 1 = two's-complement formats.
- ROUND_MODE, 1, 0 = truncate (floor); 1 = round-to-nearest, ties up (add half an output LSB, then floor).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in carries a word this cycle.
- in  in  INPUT_INTEGER_WIDTH+INPUT_DECIMAL_WIDTH  input word {integer, fraction}.
- out_valid  out  1  registered; out holds a fresh result.
- out  out  OUTPUT_INTEGER_WIDTH+OUTPUT_DECIMAL_WIDTH  quantized word {integer, fraction}.
- sat  out  1  registered; the current out was clipped to a limit.

Behaviour:
- Reset: rst_n low forces out=0, out_valid=0, sat=0 immediately, regardless of clk. This applies mid-stream too; a word accepted in the reset cycle is dropped.
- Latency: 1 cycle. A word presented with in_valid=1 at edge k produces out, sat and out_valid=1 after edge k.
- in_valid=0 at an edge: out_valid goes to 0; out and sat hold their previous values.
- Drop amount D = INPUT_DECIMAL_WIDTH − OUTPUT_DECIMAL_WIDTH.
- Rounding is performed at full precision, in a width one bit wider than the input, before any range check:
  - ROUND_MODE=1 and D>0: add 2^(D−1), then arithmetic right shift by D.
  - ROUND_MODE=0: shift only.
  - D=0: pass-through, no rounding.
- Range check is applied to the rounded value:
  - Unsigned limits: [0, 2^(OI+OD)−1].
  - Signed limits: [−2^(OI+OD−1), 2^(OI+OD−1)−1], where OI = OUTPUT_INTEGER_WIDTH and OD = OUTPUT_DECIMAL_WIDTH.
  - Out of range → out = the nearer limit and sat=1; otherwise out = the low OI+OD bits and sat=0.
- A round-up carry that crosses the maximum saturates; it must never wrap.
- Unsigned mode: every input bit is magnitude; there is no negative case.
- Signed mode: the input MSB is the sign; the shift is arithmetic.
- Parameter violations (OUTPUT_* wider than INPUT_*) stop elaboration with an error message.
- No back-pressure: the block accepts a word every cycle.

Decomposition:
- Shared package (e.g. attn_fixed_pkg):
  - Default width constants: 18/16 in, 8/8 out.
  - Round-mode encodings: RND_TRUNC=0, RND_NEAREST=1.
  - Function computing the saturation limits from widths and signedness.
- One natural combinational sub-module, quant_round_sat: round, shift and saturate logic, producing the quantized value and the sat flag.
- The top level holds only the valid pipeline and the output registers, so quant_round_sat can be reused un-registered elsewhere.

Test Plan:
- Defaults, in = {18'd180, 16'h8000} (180.5), in_valid=1 → next cycle out=16'hB480 (180.5), sat=0, out_valid=1.
- Tie rounding, in = {18'd180, 16'h0080}: ROUND_MODE=1 → out=16'hB401; ROUND_MODE=0 → out=16'hB400; sat=0 in both.
- Overflow, in = {18'd256, 16'h0000} → out=16'hFFFF, sat=1. Rounding carry, in = {18'd255, 16'hFF80} → out=16'hFFFF, sat=1.
- SIGNED=1:
  - in = −1.5 ({18'h3FFFE, 16'h8000}) → out=16'hFE80, sat=0.
  - in = {18'd200, 0} → out=16'h7FFF, sat=1.
  - in = {18'h3FF00, 0} (−256) → out=16'h8000, sat=1.
- Valid and reset:
  - Back-to-back valid words → one output per cycle, in order.
  - in_valid=0 → out holds, out_valid=0.
  - Assert rst_n low mid-stream between edges → out=0, out_valid=0, sat=0 immediately.
  - First valid output appears 1 cycle after the first valid input following reset release.

Source files
------------

// File: rtl/quantization_unit_pkg.sv
// Shared fixed-point definitions for the attention datapath re-quantizer:
// default widths, rounding-mode encodings and saturation-limit helpers.
package quantization_unit_pkg;

  localparam int DEF_IN_INT_W   = 18;
  localparam int DEF_IN_FRAC_W  = 16;
  localparam int DEF_OUT_INT_W  = 8;
  localparam int DEF_OUT_FRAC_W = 8;

  typedef enum int {
    RND_TRUNC   = 0,
    RND_NEAREST = 1
  } round_mode_e;

  // Upper or lower representable limit of a width-bit word, as a plain integer.
  function automatic longint sat_limit(int width, int is_signed, bit upper);
    if (is_signed != 0) begin
      if (upper) return (longint'(1) << (width - 1)) - 1;
      return -(longint'(1) << (width - 1));
    end
    if (upper) return (longint'(1) << width) - 1;
    return 0;
  endfunction

  function automatic longint round_bias(int drop, int mode);
    if (mode == RND_NEAREST && drop > 0) return longint'(1) << (drop - 1);
    return 0;
  endfunction

endpackage

// File: rtl/quantization_unit_if.sv
// Word-in / word-out bus of the re-quantizer; the DUT side uses the slave modport.
interface quantization_unit_if #(
  parameter int IN_W  = 34,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic [IN_W-1:0]  in;
  logic             out_valid;
  logic [OUT_W-1:0] out;
  logic             sat;

  modport master (output in_valid, in, input out_valid, out, sat);
  modport slave  (input in_valid, in, output out_valid, out, sat);
endinterface

// File: rtl/quantization_unit_round_sat.sv
// Combinational round / shift / saturate stage; kept un-registered so it can be
// dropped into other datapaths without adding latency.
module quant_round_sat
  import quantization_unit_pkg::*;
#(
  parameter int INPUT_INTEGER_WIDTH  = DEF_IN_INT_W,
  parameter int INPUT_DECIMAL_WIDTH  = DEF_IN_FRAC_W,
  parameter int OUTPUT_INTEGER_WIDTH = DEF_OUT_INT_W,
  parameter int OUTPUT_DECIMAL_WIDTH = DEF_OUT_FRAC_W,
  parameter int SIGNED               = 0,
  parameter int ROUND_MODE           = RND_NEAREST
) (
  input  logic [INPUT_INTEGER_WIDTH+INPUT_DECIMAL_WIDTH-1:0]   in_word,
  output logic [OUTPUT_INTEGER_WIDTH+OUTPUT_DECIMAL_WIDTH-1:0] q_word,
  output logic                                                 sat
);

  localparam int IW = INPUT_INTEGER_WIDTH + INPUT_DECIMAL_WIDTH;
  localparam int OW = OUTPUT_INTEGER_WIDTH + OUTPUT_DECIMAL_WIDTH;
  localparam int EW = IW + 1;
  localparam int D  = INPUT_DECIMAL_WIDTH - OUTPUT_DECIMAL_WIDTH;

  localparam logic [EW-1:0] BIAS    = EW'(round_bias(D, ROUND_MODE));
  localparam logic [EW-1:0] MAX_LIM = EW'(sat_limit(OW, SIGNED, 1'b1));
  localparam logic [EW-1:0] MIN_LIM = EW'(sat_limit(OW, SIGNED, 1'b0));

  logic [EW-1:0] ext;
  logic [EW-1:0] rounded;
  logic [EW-1:0] shifted;
  logic          over;
  logic          under;

  // The extra guard bit absorbs the rounding carry, so a carry past the top
  // of the range shows up as an overflow instead of wrapping.
  always_comb begin
    ext     = (SIGNED != 0) ? {in_word[IW-1], in_word} : {1'b0, in_word};
    rounded = ext + BIAS;
    if (SIGNED != 0) begin
      shifted = $signed(rounded) >>> D;
      over    = $signed(shifted) > $signed(MAX_LIM);
      under   = $signed(shifted) < $signed(MIN_LIM);
    end else begin
      shifted = rounded >> D;
      over    = shifted > MAX_LIM;
      under   = 1'b0;
    end
    sat = over | under;
    if (over)       q_word = MAX_LIM[OW-1:0];
    else if (under) q_word = MIN_LIM[OW-1:0];
    else            q_word = shifted[OW-1:0];
  end

endmodule

// File: rtl/quantization_unit.sv
// Registered fixed-point re-quantizer (e.g. Q18.16 -> Q8.8) with one cycle of
// latency; the arithmetic lives in quant_round_sat.
module quantization_unit
  import quantization_unit_pkg::*;
#(
  parameter int INPUT_INTEGER_WIDTH  = DEF_IN_INT_W,
  parameter int INPUT_DECIMAL_WIDTH  = DEF_IN_FRAC_W,
  parameter int OUTPUT_INTEGER_WIDTH = DEF_OUT_INT_W,
  parameter int OUTPUT_DECIMAL_WIDTH = DEF_OUT_FRAC_W,
  parameter int SIGNED               = 0,
  parameter int ROUND_MODE           = RND_NEAREST
) (
  input logic                clk,
  input logic                rst_n,
  quantization_unit_if.slave bus
);

  localparam int OW = OUTPUT_INTEGER_WIDTH + OUTPUT_DECIMAL_WIDTH;

  if (OUTPUT_INTEGER_WIDTH > INPUT_INTEGER_WIDTH ||
      OUTPUT_DECIMAL_WIDTH > INPUT_DECIMAL_WIDTH) begin : g_bad_widths
    $error("quantization_unit: output format must not be wider than the input format");
  end

  logic [OW-1:0] q_word;
  logic          q_sat;
  logic [OW-1:0] out_q;
  logic          sat_q;
  logic          valid_q;

  quant_round_sat #(
    .INPUT_INTEGER_WIDTH  (INPUT_INTEGER_WIDTH),
    .INPUT_DECIMAL_WIDTH  (INPUT_DECIMAL_WIDTH),
    .OUTPUT_INTEGER_WIDTH (OUTPUT_INTEGER_WIDTH),
    .OUTPUT_DECIMAL_WIDTH (OUTPUT_DECIMAL_WIDTH),
    .SIGNED               (SIGNED),
    .ROUND_MODE           (ROUND_MODE)
  ) u_round_sat (
    .in_word (bus.in),
    .q_word  (q_word),
    .sat     (q_sat)
  );

  // Idle cycles keep the last result visible and only drop the valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_q <= q_word;
        sat_q <= q_sat;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out       = out_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_quantization_unit.sv
// Scoreboard bench for quantization_unit: three instances (unsigned/nearest,
// signed/nearest, unsigned/truncate) share one randomized stimulus stream.
module tb_quantization_unit;

  localparam int IW    = 34;
  localparam int OW    = 16;
  localparam int DROP  = 8;
  localparam int NDUT  = 3;
  localparam int NRAND = 400;

  typedef struct {
    logic [OW-1:0] out;
    logic          sat;
    int            due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cycle_count = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t          sb [NDUT][$];
  logic [OW-1:0] last_out [NDUT];
  logic          last_sat [NDUT];

  // Configuration of each instance: signedness and round-to-nearest enable.
  localparam bit DUT_SIGNED  [NDUT] = '{1'b0, 1'b1, 1'b0};
  localparam bit DUT_NEAREST [NDUT] = '{1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cycle_count++;

  quantization_unit_if #(.IN_W(IW), .OUT_W(OW)) if_a ();
  quantization_unit_if #(.IN_W(IW), .OUT_W(OW)) if_b ();
  quantization_unit_if #(.IN_W(IW), .OUT_W(OW)) if_c ();

  quantization_unit #(.SIGNED(0), .ROUND_MODE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  quantization_unit #(.SIGNED(1), .ROUND_MODE(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  quantization_unit #(.SIGNED(0), .ROUND_MODE(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  // Reference: exact integer value, optional +half LSB, floor division, clamp.
  function automatic exp_t refModel(logic [IW-1:0] word, bit is_signed, bit nearest);
    exp_t   e;
    longint v, r, scale, max_v, min_v;
    scale = longint'(1) << DROP;
    if (is_signed) v = longint'($signed(word));
    else           v = longint'({30'b0, word});
    if (nearest) v = v + scale / 2;
    r = v / scale;
    if ((v % scale) != 0 && v < 0) r = r - 1;
    max_v = is_signed ? 32767 : 65535;
    min_v = is_signed ? -32768 : 0;
    e.sat = 1'b1;
    if (r > max_v)      r = max_v;
    else if (r < min_v) r = min_v;
    else                e.sat = 1'b0;
    e.out = OW'(r);
    e.due = 0;
    return e;
  endfunction

  task automatic compareVal(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cycle_count);
    end
  endtask

  task automatic checkPort(int idx, string name, logic ov, logic [OW-1:0] o, logic s);
    exp_t e;
    if (ov) begin
      if (sb[idx].size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s unexpected output out=%h sat=%b required=no output", name, o, s);
      end else begin
        e = sb[idx].pop_front();
        compareVal({name, " data"}, {15'b0, o, s}, {15'b0, e.out, e.sat});
        compareVal({name, " latency"}, cycle_count, e.due);
        last_out[idx] = e.out;
        last_sat[idx] = e.sat;
      end
    end else begin
      compareVal({name, " hold"}, {15'b0, o, s}, {15'b0, last_out[idx], last_sat[idx]});
      if (sb[idx].size() > 0 && sb[idx][0].due <= cycle_count) begin
        e = sb[idx].pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL %s missing output out_valid=0 required out=%h", name, e.out);
      end
    end
  endtask

  // Monitor samples on the falling edge, away from the register updates.
  always @(negedge clk) begin
    checkPort(0, "unsigned_rnd", if_a.out_valid, if_a.out, if_a.sat);
    checkPort(1, "signed_rnd", if_b.out_valid, if_b.out, if_b.sat);
    checkPort(2, "unsigned_trunc", if_c.out_valid, if_c.out, if_c.sat);
  end

  task automatic applyStimulus(logic v, logic [IW-1:0] w);
    exp_t e;
    @(posedge clk);
    #1;
    if_a.in_valid = v; if_a.in = w;
    if_b.in_valid = v; if_b.in = w;
    if_c.in_valid = v; if_c.in = w;
    if (v) begin
      for (int i = 0; i < NDUT; i++) begin
        e = refModel(w, DUT_SIGNED[i], DUT_NEAREST[i]);
        e.due = cycle_count + 1;
        sb[i].push_back(e);
      end
    end
  endtask

  task automatic checkOutput(string name, logic ov, logic [OW-1:0] o, logic s);
    compareVal(name, {15'b0, ov, o, s}, 32'd0);
  endtask

  // Reset lands mid-cycle; the word presented at that moment is dropped.
  task automatic applyReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    if_a.in_valid = 1'b0;
    if_b.in_valid = 1'b0;
    if_c.in_valid = 1'b0;
    #1;
    checkOutput("reset unsigned_rnd", if_a.out_valid, if_a.out, if_a.sat);
    checkOutput("reset signed_rnd", if_b.out_valid, if_b.out, if_b.sat);
    checkOutput("reset unsigned_trunc", if_c.out_valid, if_c.out, if_c.sat);
    for (int i = 0; i < NDUT; i++) begin
      sb[i].delete();
      last_out[i] = '0;
      last_sat[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [IW-1:0] randWord();
    logic [63:0] r64;
    logic [17:0] ip;
    r64 = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0:       return r64[IW-1:0];
      1:       ip = 18'(254 + $urandom_range(0, 3));
      2:       ip = 18'(18'h3FF7E + $urandom_range(0, 4));
      default: ip = 18'($urandom_range(0, 300));
    endcase
    return {ip, r64[15:0]};
  endfunction

  initial begin
    if_a.in_valid = 1'b0; if_a.in = '0;
    if_b.in_valid = 1'b0; if_b.in = '0;
    if_c.in_valid = 1'b0; if_c.in = '0;
    for (int i = 0; i < NDUT; i++) begin
      last_out[i] = '0;
      last_sat[i] = 1'b0;
    end
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    applyStimulus(1'b1, {18'd180, 16'h8000});
    applyStimulus(1'b1, {18'd180, 16'h0080});
    applyStimulus(1'b1, {18'd256, 16'h0000});
    applyStimulus(1'b1, {18'd255, 16'hFF80});
    applyStimulus(1'b0, '0);
    applyStimulus(1'b0, {18'd7, 16'h1234});
    applyStimulus(1'b1, {18'h3FFFE, 16'h8000});
    applyStimulus(1'b1, {18'd200, 16'h0000});
    applyStimulus(1'b1, {18'h3FF00, 16'h0000});
    applyStimulus(1'b1, {18'h3FF80, 16'h0000});
    applyStimulus(1'b1, {18'h1FFFF, 16'hFFFF});
    applyStimulus(1'b1, {18'd42, 16'h00FF});
    applyReset();

    applyStimulus(1'b1, {18'd1, 16'h0180});
    for (int n = 0; n < NRAND; n++) begin
      applyStimulus(($urandom_range(0, 3) != 0), randWord());
      if (n == NRAND / 2) applyReset();
    end
    applyStimulus(1'b0, '0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2;
    for (int i = 0; i < NDUT; i++) compareVal("scoreboard drained", sb[i].size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
